// File: rtl/wb_stream_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes each one as a
// single pipelined Wishbone write at incrementing addresses starting at BASE_ADDR.
module wb_stream_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned MAX_WORDS   = 1024,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    input  logic        byte_last_i,
    output logic        byte_ready_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] word_count_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_REQUEST, S_WAIT_ACK, S_DONE, S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic [1:0]  lane_q, lane_d;
    logic        last_q, last_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] tmo_q, tmo_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;

    logic [31:0] cnt_inc;
    logic [31:0] tmo_inc;
    logic        acked;

    assign cnt_inc = cnt_q + 32'd1;
    assign tmo_inc = tmo_q + 32'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            adr_q   <= BASE_ADDR;
            dat_q   <= '0;
            sel_q   <= '0;
            lane_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            lane_q  <= lane_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        lane_d  = lane_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        // An ack only counts once the request has been (or is being) accepted.
        acked   = wb_ack_i && ((state_q == S_WAIT_ACK) || !wb_stall_i);

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    state_d = S_COLLECT;
                    adr_d   = BASE_ADDR;
                    dat_d   = '0;
                    sel_d   = '0;
                    lane_d  = '0;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_COLLECT: begin
                if (byte_valid_i) begin
                    dat_d[{lane_q, 3'b000} +: 8] = byte_i;
                    sel_d[lane_q] = 1'b1;
                    lane_d = lane_q + 2'd1;
                    if ((lane_q == 2'd3) || byte_last_i) begin
                        state_d = S_REQUEST;
                        last_d  = byte_last_i;
                        tmo_d   = '0;
                    end
                end
            end
            S_REQUEST, S_WAIT_ACK: begin
                if (acked) begin
                    cnt_d  = cnt_inc;
                    adr_d  = adr_q + 32'd4;
                    dat_d  = '0;
                    sel_d  = '0;
                    lane_d = '0;
                    if (last_q)
                        state_d = S_DONE;
                    else if (cnt_inc == MAX_WORDS)
                        state_d = S_ERROR;
                    else
                        state_d = S_COLLECT;
                end else if (tmo_inc == ACK_TIMEOUT) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_inc;
                    if ((state_q == S_REQUEST) && !wb_stall_i)
                        state_d = S_WAIT_ACK;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus strobes are registered from the next state so they track it exactly.
    always_comb begin
        cyc_d        = (state_d == S_REQUEST) || (state_d == S_WAIT_ACK);
        stb_d        = (state_d == S_REQUEST);
        we_d         = cyc_d;
        byte_ready_o = (state_q == S_COLLECT);
        busy_o       = (state_q == S_COLLECT) || (state_q == S_REQUEST) ||
                       (state_q == S_WAIT_ACK);
        done_o       = (state_q == S_DONE);
        error_o      = (state_q == S_ERROR);
    end

    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign wb_sel_o     = sel_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = stb_q;
    assign wb_we_o      = we_q;
    assign word_count_o = cnt_q;

endmodule

// File: tb/tb_wb_stream_loader.sv
// Randomized bench for wb_stream_loader: a byte source and Wishbone slave driven
// cycle by cycle, with expected writes derived from little-endian packing of the stream.
module tb_wb_stream_loader;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          MW   = 4;
    localparam int          TMO  = 16;

    logic        clk = 1'b0;
    logic        rst_i, start_i, byte_valid_i, byte_last_i, wb_ack_i, wb_stall_i;
    logic [7:0]  byte_i;
    logic        byte_ready_o, wb_we_o, wb_stb_o, wb_cyc_o, busy_o, done_o, error_o;
    logic [31:0] wb_adr_o, wb_dat_o, word_count_o;
    logic [3:0]  wb_sel_o;

    wb_stream_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MW), .ACK_TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .byte_i(byte_i),
        .byte_valid_i(byte_valid_i), .byte_last_i(byte_last_i),
        .byte_ready_o(byte_ready_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
        .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .word_count_o(word_count_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]  src_q[$];
    bit          src_last_en;
    logic [31:0] exp_adr[$];
    logic [31:0] exp_dat[$];
    logic [3:0]  exp_sel[$];
    int          exp_wc;
    bit          exp_done;

    bit          noack, stall_en, outstanding, prev_stalled;
    int          force_stall, stall_run, ack_dly, n_acc;
    logic [31:0] prev_adr, prev_dat, last_adr, last_dat;
    logic [3:0]  prev_sel, last_sel;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a falling edge: observe outputs, then set inputs for the next rising edge.
    task automatic drive_cycle();
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        byte_i       = 8'($urandom);
        if (src_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            byte_valid_i = 1'b1;
            byte_i       = src_q[0];
            byte_last_i  = src_last_en && (src_q.size() == 1);
            if (byte_ready_o) void'(src_q.pop_front());
        end

        wb_ack_i   = 1'b0;
        wb_stall_i = 1'b0;
        if (prev_stalled) begin
            chk("stall_stb", wb_stb_o, 1);
            chk("stall_adr", wb_adr_o, prev_adr);
            chk("stall_dat", wb_dat_o, prev_dat);
            chk("stall_sel", wb_sel_o, prev_sel);
        end
        if (wb_stb_o) begin
            if (force_stall > 0) begin
                wb_stall_i = 1'b1;
                force_stall--;
            end else if (stall_en && stall_run < 3 && $urandom_range(0, 2) == 0) begin
                wb_stall_i = 1'b1;
            end
            stall_run = wb_stall_i ? stall_run + 1 : 0;
            prev_stalled = wb_stall_i;
            prev_adr = wb_adr_o;
            prev_dat = wb_dat_o;
            prev_sel = wb_sel_o;
            if (!wb_stall_i) begin
                n_acc++;
                chk("wr_we", wb_we_o, 1);
                chk("wr_cyc", wb_cyc_o, 1);
                last_adr = wb_adr_o;
                last_dat = wb_dat_o;
                last_sel = wb_sel_o;
                if (exp_adr.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL wr_extra got adr=%h exp=no write", wb_adr_o);
                end else begin
                    chk("wr_adr", wb_adr_o, exp_adr.pop_front());
                    chk("wr_dat", wb_dat_o, exp_dat.pop_front());
                    chk("wr_sel", wb_sel_o, exp_sel.pop_front());
                end
                if (!noack) begin
                    ack_dly = $urandom_range(0, 3);
                    if (ack_dly == 0) wb_ack_i = 1'b1;
                    else outstanding = 1'b1;
                end
            end
        end else begin
            prev_stalled = 1'b0;
            stall_run = 0;
            if (outstanding) begin
                ack_dly--;
                if (ack_dly == 0) begin
                    wb_ack_i = 1'b1;
                    outstanding = 1'b0;
                end
            end else if (!wb_cyc_o) begin
                wb_ack_i = ($urandom_range(0, 3) == 0);
            end
        end
    endtask

    task automatic prep(input bit use_last);
        int n, nw;
        logic [31:0] d;
        logic [3:0]  s;
        n  = src_q.size();
        nw = use_last ? (n + 3) / 4 : n / 4;
        if (nw > MW) nw = MW;
        if (noack && nw > 1) nw = 1;
        exp_adr.delete();
        exp_dat.delete();
        exp_sel.delete();
        for (int w = 0; w < nw; w++) begin
            d = '0;
            s = '0;
            for (int j = 0; j < 4; j++) begin
                if (4 * w + j < n) begin
                    d = d | (32'(src_q[4 * w + j]) << (8 * j));
                    s = s | 4'(1 << j);
                end
            end
            exp_adr.push_back(BASE + 32'(4 * w));
            exp_dat.push_back(d);
            exp_sel.push_back(s);
        end
        exp_wc   = noack ? 0 : nw;
        exp_done = use_last && !noack;
        src_last_en = use_last;
    endtask

    task automatic start_load(input bit use_last);
        prep(use_last);
        n_acc = 0;
        outstanding = 1'b0;
        prev_stalled = 1'b0;
        stall_run = 0;
        start_i = 1'b1;
        drive_cycle();
        @(negedge clk);
        start_i = 1'b0;
        chk("st_ready", byte_ready_o, 1);
        chk("st_busy", busy_o, 1);
        chk("st_adr", wb_adr_o, BASE);
        chk("st_wc", word_count_o, 0);
        chk("st_sel", wb_sel_o, 0);
    endtask

    task automatic finish_load(output int cyc_cnt);
        int nw_exp;
        bit ok;
        nw_exp  = exp_adr.size();
        cyc_cnt = 0;
        ok      = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (done_o || error_o) begin
                ok = 1'b1;
                break;
            end
            if (wb_cyc_o) cyc_cnt++;
            drive_cycle();
            @(negedge clk);
        end
        chk("end_reached", ok, 1);
        chk("end_done", done_o, exp_done);
        chk("end_error", error_o, !exp_done);
        chk("end_busy", busy_o, 0);
        chk("end_wc", word_count_o, exp_wc);
        chk("end_adr", wb_adr_o, BASE + 32'(4 * exp_wc));
        chk("end_ready", byte_ready_o, 0);
        chk("end_cyc", wb_cyc_o, 0);
        chk("end_stb", wb_stb_o, 0);
        chk("end_nwr", n_acc, nw_exp);
        chk("end_pending", exp_adr.size(), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cyc"}, wb_cyc_o, 0);
        chk({tag, "_stb"}, wb_stb_o, 0);
        chk({tag, "_we"}, wb_we_o, 0);
        chk({tag, "_ready"}, byte_ready_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_error"}, error_o, 0);
        chk({tag, "_sel"}, wb_sel_o, 0);
        chk({tag, "_dat"}, wb_dat_o, 0);
        chk({tag, "_adr"}, wb_adr_o, BASE);
        chk({tag, "_wc"}, word_count_o, 0);
    endtask

    initial begin
        int cc;
        bit hit;
        rst_i = 1'b1; start_i = 1'b0; byte_i = '0; byte_valid_i = 1'b0;
        byte_last_i = 1'b0; wb_ack_i = 1'b0; wb_stall_i = 1'b0;
        noack = 1'b0; stall_en = 1'b0; force_stall = 0; outstanding = 1'b0;
        prev_stalled = 1'b0; stall_run = 0; n_acc = 0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_i = 1'b0;
        @(negedge clk);

        // single full word
        src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        start_load(1'b1);
        finish_load(cc);
        chk("t1_adr", last_adr, BASE);
        chk("t1_dat", last_dat, 32'h4433_2211);
        chk("t1_sel", last_sel, 4'hF);

        // full word then partial word
        src_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        start_load(1'b1);
        finish_load(cc);
        chk("t2_adr", last_adr, BASE + 32'd4);
        chk("t2_dat", last_dat, 32'h0000_0605);
        chk("t2_sel", last_sel, 4'h3);

        // three stalled cycles before the accept
        src_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        force_stall = 3;
        start_load(1'b1);
        finish_load(cc);

        // slave never acknowledges
        noack = 1'b1;
        src_q = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
        start_load(1'b1);
        finish_load(cc);
        chk("tmo_cycles", cc, TMO);
        noack = 1'b0;

        // overrun of MAX_WORDS without a last byte (also restarts from ERROR)
        src_q.delete();
        for (int i = 0; i < 4 * MW + 4; i++) src_q.push_back(8'($urandom));
        start_load(1'b0);
        finish_load(cc);

        // randomized loads with random stalls and ack delays
        stall_en = 1'b1;
        for (int it = 0; it < 20; it++) begin
            src_q.delete();
            for (int i = 0; i < $urandom_range(1, 4 * MW); i++) src_q.push_back(8'($urandom));
            start_load(1'b1);
            finish_load(cc);
        end
        stall_en = 1'b0;

        // reset while waiting for an ack, followed by a late ack
        noack = 1'b1;
        src_q = '{8'h10, 8'h20, 8'h30, 8'h40};
        start_load(1'b1);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (wb_cyc_o && !wb_stb_o) begin
                hit = 1'b1;
                break;
            end
            drive_cycle();
            @(negedge clk);
        end
        chk("wa_reached", hit, 1);
        rst_i = 1'b1;
        wb_ack_i = 1'b0;
        byte_valid_i = 1'b0;
        @(negedge clk);
        chk_reset_vals("mid_rst");
        rst_i = 1'b0;
        wb_ack_i = 1'b1;
        @(negedge clk);
        wb_ack_i = 1'b0;
        chk_reset_vals("late_ack");
        noack = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_stream_loader.md
Name: wb_stream_loader

Overview:
- Wishbone (pipelined) master that sits directly upstream of the memory's Wishbone slave interface.
- Accepts a byte stream (e.g. from a UART boot path) and packs it little-endian into 32-bit words.
- Issues one single-write Wishbone cycle per word at incrementing addresses from BASE_ADDR, handling stall, ack and ack timeout.
- Used to preload BRAM contents at boot.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-byte aligned.
- MAX_WORDS, 1024, maximum words per load; exceeding it is an error.
- ACK_TIMEOUT, 16, max cycles from stb assertion to ack before aborting.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  one-cycle pulse; begins a load (honoured in IDLE, DONE or ERROR only).
- byte_i  in  8  stream data.
- byte_valid_i  in  1  stream data valid.
- byte_last_i  in  1  marks final byte of the load; qualified by byte_valid_i.
- byte_ready_o  out  1  loader accepts the byte this cycle.
- wb_adr_o  out  32  Wishbone address.
- wb_dat_o  out  32  Wishbone write data.
- wb_we_o  out  1  write enable, always 1 while wb_cyc_o.
- wb_sel_o  out  4  byte lane selects.
- wb_stb_o  out  1  strobe.
- wb_cyc_o  out  1  cycle.
- wb_ack_i  in  1  slave acknowledge.
- wb_stall_i  in  1  slave stall.
- busy_o  out  1  high in COLLECT, REQUEST and WAIT_ACK.
- done_o  out  1  high in DONE.
- error_o  out  1  high in ERROR.
- word_count_o  out  32  words acknowledged in current/last load.

Behaviour:
- Reset: state IDLE. wb_cyc_o, wb_stb_o, wb_we_o, byte_ready_o, busy_o, done_o, error_o = 0. wb_sel_o = 0, wb_dat_o = 0, wb_adr_o = BASE_ADDR, word_count_o = 0. Reset mid-transfer drops cyc/stb the next cycle with no further handshake.
- All Wishbone outputs are registered.
- IDLE/DONE/ERROR + start_i:
  - go to COLLECT.
  - clear word_count_o, lane index, wb_sel_o and wb_dat_o.
  - wb_adr_o = BASE_ADDR.
- COLLECT:
  - byte_ready_o = 1 (combinational from state).
  - On byte_valid_i: byte goes into wb_dat_o[8k+7:8k] with k = lane index; wb_sel_o[k] set; index incremented.
  - If k == 3 or byte_last_i: go to REQUEST, latching last flag.
  - Unfilled lanes stay 0 with sel bit 0; a partial final word is written with partial sel (e.g. 2 bytes -> sel 4'b0011).
- REQUEST:
  - wb_cyc_o = wb_stb_o = wb_we_o = 1; timeout counter starts at 0.
  - Edge with wb_stall_i = 0: request accepted; next cycle stb = 0, cyc stays 1, go to WAIT_ACK.
  - While stalled, all outputs are held stable.
  - An ack sampled on the accepting edge completes immediately, as in WAIT_ACK.
- WAIT_ACK:
  - cyc = 1, stb = 0.
  - On ack: cyc drops next cycle; word_count_o += 1; wb_adr_o += 4; sel and data cleared; lane index = 0.
  - Then, in priority order:
    - if last latched -> DONE;
    - else if new word_count_o == MAX_WORDS -> ERROR;
    - else -> COLLECT.
- Timeout:
  - Counter increments each cycle in REQUEST/WAIT_ACK without ack.
  - When it reaches ACK_TIMEOUT: go to ERROR, cyc/stb dropped next cycle, word_count_o unchanged.
  - An ack arriving in the same cycle the limit is reached wins over the timeout.
- wb_ack_i outside a cycle is ignored.
- Stream input is ignored outside COLLECT (byte_ready_o = 0).
- DONE/ERROR hold wb_adr_o and word_count_o until the next start_i.
- start_i while busy is ignored.
- Address arithmetic is 32-bit modulo.
- Minimum per-word latency (no stall, ack one cycle after accept): 4 byte cycles + 1 REQUEST + 1 WAIT_ACK.

Test Plan:
- start, bytes 11,22,33,44 (last on 44), slave acks 1 cycle after accept -> one write: adr 0x0, dat 0x44332211, sel 4'hF; DONE; word_count_o = 1.
- start, 6 bytes 01..06, last on 06 -> writes 0x04030201/sel F at 0x0, then 0x00000605/sel 3 at 0x4; word_count_o = 2; done_o = 1.
- wb_stall_i high 3 cycles during REQUEST -> stb/adr/dat/sel stable all 3 cycles; exactly one accept; ack completes normally.
- slave never acks, ACK_TIMEOUT = 16 -> error_o after 16 cycles, cyc dropped, word_count_o = 0; a new start_i returns to COLLECT with adr = BASE_ADDR.
- MAX_WORDS = 2, 12 bytes without last -> 2 acked writes, then ERROR; byte_ready_o = 0; third word never written.
- rst_i asserted in WAIT_ACK -> next cycle all outputs at reset values, state IDLE; a late ack is ignored.
